// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM states,
// fault codes, the NOP used for faulted fetches and the fetch-word selector.
package ifu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  localparam logic [1:0] FLT_NONE = 2'd0;
  localparam logic [1:0] FLT_BUS  = 2'd1;
  localparam logic [1:0] FLT_TMO  = 2'd2;
  localparam logic [1:0] FLT_MIS  = 2'd3;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // PC bit 2 picks the upper or lower 32-bit slot of the 8-byte fetch word.
  function automatic logic [31:0] word_select(input logic [63:0] word, input logic hi);
    return hi ? word[63:32] : word[31:0];
  endfunction

endpackage

// File: rtl/ifu_wdog.sv
// Response watchdog: counts enabled cycles after a clear and flags expiry once
// TIMEOUT_CYC cycles have been spent waiting. Saturates, never wraps.
module ifu_wdog #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int            CW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] SAT  = CW'(TIMEOUT_CYC);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != SAT)) begin
      count <= count + 1'b1;
    end
  end

  // Expiry fires in the last allowed wait cycle, so the owner leaves on that edge.
  assign expire = enable && (count >= LAST);

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: PC handshake in, one memory read, instruction out.
// Optional misalignment check enabled by defining IFU_ALIGN_CHK_EN.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_i,
  input  logic            pc_valid_i,
  output logic            pc_ready_o,
  input  logic            flush_i,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [63:0]     mem_rdata_i,
  input  logic            mem_err_i,
  output logic            inst_valid_o,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  output logic [1:0]      inst_fault_o,
  input  logic            inst_ready_i
);

  state_t          state, state_nx;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     inst_q, inst_d;
  logic [1:0]      fault_q, fault_d;
  logic            ld_pc, ld_inst;
  logic            wd_clear, wd_en, wd_expire;
  logic            misaligned;

`ifdef IFU_ALIGN_CHK_EN
  assign misaligned = |pc_i[1:0];
`else
  assign misaligned = 1'b0;
`endif

  assign wd_clear = (state == S_REQ) && mem_gnt_i;
  assign wd_en    = (state == S_WAIT) || (state == S_DRAIN);

  ifu_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (wd_en),
    .expire (wd_expire)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_nx = state;
    ld_pc    = 1'b0;
    ld_inst  = 1'b0;
    inst_d   = NOP_INST;
    fault_d  = FLT_NONE;
    case (state)
      S_IDLE: begin
        if (!flush_i && pc_valid_i) begin
          ld_pc = 1'b1;
          if (misaligned) begin
            state_nx = S_HOLD;
            ld_inst  = 1'b1;
            fault_d  = FLT_MIS;
          end else begin
            state_nx = S_REQ;
          end
        end
      end
      S_REQ: begin
        // A granted request still owes one response, which DRAIN must absorb.
        if (flush_i)        state_nx = mem_gnt_i ? S_DRAIN : S_IDLE;
        else if (mem_gnt_i) state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (flush_i) begin
          state_nx = mem_rvalid_i ? S_IDLE : S_DRAIN;
        end else if (mem_rvalid_i) begin
          state_nx = S_HOLD;
          ld_inst  = 1'b1;
          if (mem_err_i) fault_d = FLT_BUS;
          else           inst_d  = word_select(mem_rdata_i, pc_q[2]);
        end else if (wd_expire) begin
          state_nx = S_HOLD;
          ld_inst  = 1'b1;
          fault_d  = FLT_TMO;
        end
      end
      S_HOLD: begin
        if (flush_i || inst_ready_i) state_nx = S_IDLE;
      end
      S_DRAIN: begin
        if (mem_rvalid_i || wd_expire) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // NOTE: the datapath registers are few and drive outputs that must read 0
  // in reset, so they take the asynchronous reset rather than relying on loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      inst_q  <= '0;
      fault_q <= FLT_NONE;
    end else begin
      if (ld_pc) pc_q <= pc_i;
      if (ld_inst) begin
        inst_q  <= inst_d;
        fault_q <= fault_d;
      end
    end
  end

  // rst gates pc_ready_o so every output reads 0 while reset is held.
  assign pc_ready_o   = (state == S_IDLE) && !flush_i && !rst;
  assign mem_req_o    = (state == S_REQ);
  assign mem_addr_o   = {pc_q[XLEN-1:3], 3'b000};
  assign inst_valid_o = (state == S_HOLD);
  assign inst_o       = inst_q;
  assign inst_pc_o    = pc_q;
  assign inst_fault_o = fault_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Scenario bench for ifu_fetch: expected instructions are queued when the
// memory response (or its absence) is driven and compared when HOLD appears.
module tb_ifu_fetch;
  import ifu_pkg::*;

  localparam int XLEN = 64;
  localparam int TMO  = 4;
  localparam logic [63:0] RDATA1 = 64'h0000_0093_0000_0013;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [XLEN-1:0] pc_i = '0;
  logic            pc_valid_i = 1'b0;
  logic            pc_ready_o;
  logic            flush_i = 1'b0;
  logic            mem_req_o;
  logic [XLEN-1:0] mem_addr_o;
  logic            mem_gnt_i = 1'b0;
  logic            mem_rvalid_i = 1'b0;
  logic [63:0]     mem_rdata_i = '0;
  logic            mem_err_i = 1'b0;
  logic            inst_valid_o;
  logic [31:0]     inst_o;
  logic [XLEN-1:0] inst_pc_o;
  logic [1:0]      inst_fault_o;
  logic            inst_ready_i = 1'b0;

  always #5 clk = ~clk;

  ifu_fetch #(.XLEN(XLEN), .TIMEOUT_CYC(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .pc_valid_i   (pc_valid_i),
    .pc_ready_o   (pc_ready_o),
    .flush_i      (flush_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .mem_err_i    (mem_err_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .inst_fault_o (inst_fault_o),
    .inst_ready_i (inst_ready_i)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [1:0]  fault;
  } exp_t;

  exp_t sb[$];
  exp_t got, exp_v;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [164:0] outs;
  assign outs = {pc_ready_o, mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_pc_o, inst_fault_o};
  assign got  = {inst_o, inst_pc_o, inst_fault_o};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_pc(input logic [63:0] pc);
    pc_i       = pc;
    pc_valid_i = 1'b1;
    step();
    pc_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (outs !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %h, want 0", outs);
    end
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({pc_ready_o, mem_req_o, inst_valid_o} !== 3'b100) begin
      n_errors++;
      $display("FAIL reset_release: ready/req/valid=%b, want 100", {pc_ready_o, mem_req_o, inst_valid_o});
    end
    step();
  endtask

  task automatic test_basic();
    pc_i = 64'h8000_0000; pc_valid_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (pc_ready_o !== 1'b1) begin
      n_errors++; $display("FAIL basic_accept: pc_ready=%b, want 1", pc_ready_o);
    end
    step(); pc_valid_i = 1'b0; mem_gnt_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 64'h8000_0000) begin
      n_errors++; $display("FAIL basic_req: req=%b addr=%h, want 1 80000000", mem_req_o, mem_addr_o);
    end
    step(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = RDATA1;
    sb.push_back(exp_t'{32'h0000_0013, 64'h8000_0000, FLT_NONE});
    @(negedge clk);
    n_checks++;
    if (inst_valid_o !== 1'b0) begin
      n_errors++; $display("FAIL basic_early_valid: valid=%b in N+2, want 0", inst_valid_o);
    end
    step(); mem_rvalid_i = 1'b0; mem_rdata_i = '0; inst_ready_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (inst_valid_o !== 1'b1 || sb.size() == 0) begin
      n_errors++; $display("FAIL basic_out: valid=%b queued=%0d in N+3, want valid", inst_valid_o, sb.size());
    end else begin
      exp_v = sb.pop_front();
      if (got !== exp_v) begin
        n_errors++; $display("FAIL basic_out: got %h/%h/%0d, want %h/%h/%0d", inst_o, inst_pc_o, inst_fault_o, exp_v.inst, exp_v.pc, exp_v.fault);
      end
    end
    step(); inst_ready_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (inst_valid_o !== 1'b0 || pc_ready_o !== 1'b1) begin
      n_errors++; $display("FAIL basic_back_idle: valid=%b ready=%b, want 0 1", inst_valid_o, pc_ready_o);
    end
    step();
  endtask

  task automatic test_gnt_stall();
    issue_pc(64'h8000_0004);
    for (int i = 0; i < 4; i++) begin
      mem_gnt_i = (i == 3);
      @(negedge clk);
      n_checks++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== 64'h8000_0000) begin
        n_errors++; $display("FAIL stall_addr[%0d]: req=%b addr=%h, want 1 80000000", i, mem_req_o, mem_addr_o);
      end
      step();
    end
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = RDATA1;
    sb.push_back(exp_t'{32'h0000_0093, 64'h8000_0004, FLT_NONE});
    step(); mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    pc_i = 64'hDEAD_0000; pc_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (inst_valid_o !== 1'b1 || pc_ready_o !== 1'b0 || got !== sb[0]) begin
        n_errors++; $display("FAIL stall_hold[%0d]: valid=%b ready=%b out=%h/%h/%0d, want 1 0 %h/%h/%0d", i, inst_valid_o, pc_ready_o, inst_o, inst_pc_o, inst_fault_o, sb[0].inst, sb[0].pc, sb[0].fault);
      end
      step();
    end
    pc_valid_i = 1'b0; inst_ready_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (inst_valid_o !== 1'b1 || sb.size() == 0) begin
      n_errors++; $display("FAIL stall_out: valid=%b queued=%0d, want valid", inst_valid_o, sb.size());
    end else begin
      exp_v = sb.pop_front();
      if (got !== exp_v) begin
        n_errors++; $display("FAIL stall_out: got %h/%h/%0d, want %h/%h/%0d", inst_o, inst_pc_o, inst_fault_o, exp_v.inst, exp_v.pc, exp_v.fault);
      end
    end
    step(); inst_ready_i = 1'b0;
  endtask

  task automatic test_faults();
    int waited;
    issue_pc(64'h8000_0008);
    mem_gnt_i = 1'b1; step(); mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_err_i = 1'b1; mem_rdata_i = '1;
    sb.push_back(exp_t'{NOP_INST, 64'h8000_0008, FLT_BUS});
    step(); mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = '0; inst_ready_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (inst_valid_o !== 1'b1 || sb.size() == 0) begin
      n_errors++; $display("FAIL bus_err_out: valid=%b queued=%0d, want valid", inst_valid_o, sb.size());
    end else begin
      exp_v = sb.pop_front();
      if (got !== exp_v) begin
        n_errors++; $display("FAIL bus_err_out: got %h/%h/%0d, want %h/%h/%0d", inst_o, inst_pc_o, inst_fault_o, exp_v.inst, exp_v.pc, exp_v.fault);
      end
    end
    step(); inst_ready_i = 1'b0;

    issue_pc(64'h8000_000C);
    mem_gnt_i = 1'b1; step(); mem_gnt_i = 1'b0;
    sb.push_back(exp_t'{NOP_INST, 64'h8000_000C, FLT_TMO});
    waited = 0;
    @(negedge clk);
    while (inst_valid_o !== 1'b1 && waited < 20) begin
      step(); @(negedge clk); waited++;
    end
    n_checks++;
    if (waited != TMO) begin
      n_errors++; $display("FAIL tmo_latency: waited %0d cycles, want %0d", waited, TMO);
    end
    n_checks++;
    if (inst_valid_o !== 1'b1 || sb.size() == 0) begin
      n_errors++; $display("FAIL tmo_out: valid=%b queued=%0d, want valid", inst_valid_o, sb.size());
    end else begin
      exp_v = sb.pop_front();
      if (got !== exp_v) begin
        n_errors++; $display("FAIL tmo_out: got %h/%h/%0d, want %h/%h/%0d", inst_o, inst_pc_o, inst_fault_o, exp_v.inst, exp_v.pc, exp_v.fault);
      end
    end
    inst_ready_i = 1'b1; step(); inst_ready_i = 1'b0;
  endtask

  task automatic test_flush();
    logic seen;
    mem_rvalid_i = 1'b1; mem_rdata_i = 64'h5555_6666_7777_8888;
    step(); mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    @(negedge clk);
    n_checks++;
    if (inst_valid_o !== 1'b0 || pc_ready_o !== 1'b1) begin
      n_errors++; $display("FAIL stray_rvalid: valid=%b ready=%b, want 0 1", inst_valid_o, pc_ready_o);
    end
    step();

    issue_pc(64'h8000_0018);
    flush_i = 1'b1; step(); flush_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_req_o !== 1'b0 || pc_ready_o !== 1'b1) begin
      n_errors++; $display("FAIL flush_req_drop: req=%b ready=%b, want 0 1", mem_req_o, pc_ready_o);
    end
    step();

    issue_pc(64'h8000_0020);
    mem_gnt_i = 1'b1; step(); mem_gnt_i = 1'b0;
    flush_i = 1'b1; step(); flush_i = 1'b0;
    seen = 1'b0;
    @(negedge clk);
    seen |= inst_valid_o;
    n_checks++;
    if (pc_ready_o !== 1'b0) begin
      n_errors++; $display("FAIL drain_busy: ready=%b, want 0", pc_ready_o);
    end
    step(); mem_rvalid_i = 1'b1; mem_rdata_i = 64'h1111_2222_3333_4444;
    @(negedge clk); seen |= inst_valid_o;
    step(); mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); seen |= inst_valid_o;
      if (i == 0) begin
        n_checks++;
        if (pc_ready_o !== 1'b1) begin
          n_errors++; $display("FAIL drain_done: ready=%b, want 1", pc_ready_o);
        end
      end
      step();
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_errors++; $display("FAIL flush_no_pulse: inst_valid seen=%b, want 0", seen);
    end

    issue_pc(64'h8000_0010);
    mem_gnt_i = 1'b1; step(); mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 64'hAAAA_BBBB_1234_5678;
    sb.push_back(exp_t'{32'h1234_5678, 64'h8000_0010, FLT_NONE});
    step(); mem_rvalid_i = 1'b0; mem_rdata_i = '0; inst_ready_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (inst_valid_o !== 1'b1 || sb.size() == 0) begin
      n_errors++; $display("FAIL post_flush_out: valid=%b queued=%0d, want valid", inst_valid_o, sb.size());
    end else begin
      exp_v = sb.pop_front();
      if (got !== exp_v) begin
        n_errors++; $display("FAIL post_flush_out: got %h/%h/%0d, want %h/%h/%0d", inst_o, inst_pc_o, inst_fault_o, exp_v.inst, exp_v.pc, exp_v.fault);
      end
    end
    step(); inst_ready_i = 1'b0;

    issue_pc(64'h8000_0028);
    mem_gnt_i = 1'b1; step(); mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = RDATA1;
    step(); mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    flush_i = 1'b1; inst_ready_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (inst_valid_o !== 1'b1 || pc_ready_o !== 1'b0) begin
      n_errors++; $display("FAIL hold_before_flush: valid=%b ready=%b, want 1 0", inst_valid_o, pc_ready_o);
    end
    step(); flush_i = 1'b0; inst_ready_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (inst_valid_o !== 1'b0 || pc_ready_o !== 1'b1) begin
      n_errors++; $display("FAIL flush_hold_drop: valid=%b ready=%b, want 0 1", inst_valid_o, pc_ready_o);
    end
    step();
  endtask

  task automatic test_align();
    issue_pc(64'h8000_0002);
`ifdef IFU_ALIGN_CHK_EN
    sb.push_back(exp_t'{NOP_INST, 64'h8000_0002, FLT_MIS});
    @(negedge clk);
    n_checks++;
    if (mem_req_o !== 1'b0) begin
      n_errors++; $display("FAIL align_no_req: req=%b, want 0", mem_req_o);
    end
`else
    @(negedge clk);
    n_checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 64'h8000_0000) begin
      n_errors++; $display("FAIL align_fetch_req: req=%b addr=%h, want 1 80000000", mem_req_o, mem_addr_o);
    end
    mem_gnt_i = 1'b1; step(); mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = RDATA1;
    sb.push_back(exp_t'{32'h0000_0013, 64'h8000_0002, FLT_NONE});
    step(); mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    @(negedge clk);
`endif
    n_checks++;
    if (inst_valid_o !== 1'b1 || sb.size() == 0) begin
      n_errors++; $display("FAIL align_out: valid=%b queued=%0d, want valid", inst_valid_o, sb.size());
    end else begin
      exp_v = sb.pop_front();
      if (got !== exp_v) begin
        n_errors++; $display("FAIL align_out: got %h/%h/%0d, want %h/%h/%0d", inst_o, inst_pc_o, inst_fault_o, exp_v.inst, exp_v.pc, exp_v.fault);
      end
    end
    inst_ready_i = 1'b1; step(); inst_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    issue_pc(64'h8000_0030);
    mem_gnt_i = 1'b1; step(); mem_gnt_i = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (outs !== '0) begin
      n_errors++; $display("FAIL async_reset: got %h, want 0", outs);
    end
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({pc_ready_o, mem_req_o, inst_valid_o} !== 3'b100) begin
      n_errors++; $display("FAIL post_reset_idle: ready/req/valid=%b, want 100", {pc_ready_o, mem_req_o, inst_valid_o});
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_gnt_stall();
    test_faults();
    test_flush();
    test_align();
    test_reset_mid();
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++; $display("FAIL scoreboard_empty: %0d entries left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
